// File: rtl/display_source_arbiter.sv
// Round-robin arbiter sharing one seven-segment display between NUM_REQ producers.
// Each grant captures one signed value and holds it for DWELL_CYCLES cycles.
module display_source_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned DWELL_CYCLES = 100_000_000
) (
  input  logic                   clk_100MHz,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_value,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             value,
  output logic [1:0]             owner,
  output logic                   active
);

  localparam int unsigned CntW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StDwell} state_e;

  state_e              state_q, state_d;
  logic [7:0]          value_q, value_d;
  logic [1:0]          owner_q, owner_d;
  logic                active_q, active_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                any_valid;
  logic                pick_found;
  logic [1:0]          pick;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                gnt_valid;
  logic [7:0]          gnt_value;
  logic [1:0]          rr_next;

  assign any_valid = |req_valid;

  // First pass covers rr_ptr..NUM_REQ-1, second pass wraps to 0..rr_ptr-1.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!pick_found && req_valid[j] && (2'(j) >= rr_ptr_q)) begin
        pick_found = 1'b1;
        pick       = 2'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!pick_found && req_valid[j]) begin
        pick_found = 1'b1;
        pick       = 2'(j);
      end
    end
  end

  always_comb begin
    pick_onehot = '0;
    gnt_valid   = 1'b0;
    gnt_value   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      pick_onehot[j] = (pick == 2'(j));
      if (gnt_q == 2'(j)) begin
        gnt_valid = req_valid[j];
        gnt_value = req_value[8*j +: 8];
      end
    end
  end

  assign rr_next = (gnt_q == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    owner_d  = owner_q;
    active_d = active_q;
    ready_d  = '0;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          state_d = StGrant;
          ready_d = pick_onehot;
          gnt_d   = pick;
        end
      end
      StGrant: begin
        // A requester that withdrew during its grant cycle forfeits the slot.
        if (gnt_valid) begin
          value_d  = gnt_value;
          owner_d  = gnt_q;
          rr_ptr_d = rr_next;
          cnt_d    = CntLoad;
          active_d = 1'b1;
          state_d  = StDwell;
        end else begin
          state_d = StIdle;
        end
      end
      StDwell: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          active_d = 1'b0;
          if (any_valid) begin
            state_d = StGrant;
            ready_d = pick_onehot;
            gnt_d   = pick;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      value_q  <= '0;
      owner_q  <= '0;
      active_q <= 1'b0;
      ready_q  <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      owner_q  <= owner_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready = ready_q;
  assign value     = value_q;
  assign owner     = owner_q;
  assign active    = active_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Scoreboard bench for display_source_arbiter: expected grants are queued at request time
// and a negedge monitor pops and compares them whenever req_ready pulses.
module tb_display_source_arbiter;

  localparam int unsigned NReq  = 3;
  localparam int unsigned Dwell = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [23:0] req_value;
  logic [2:0]  req_ready;
  logic [7:0]  value;
  logic [1:0]  owner;
  logic        active;

  always #5 clk = ~clk;

  display_source_arbiter #(
    .NUM_REQ      (NReq),
    .DWELL_CYCLES (Dwell)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_value  (req_value),
    .req_ready  (req_ready),
    .value      (value),
    .owner      (owner),
    .active     (active)
  );

  typedef struct packed {
    logic [2:0] rdy;
    logic       cap;
    logic [7:0] val;
    logic [1:0] own;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [2:0] hold     = 3'b000;
  logic [2:0] rdy_seen = 3'b000;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per req_ready pulse, checks capture on the next cycle.
  exp_t       cur;
  bit         cap_pend = 1'b0;
  logic [2:0] prev_rdy = 3'b000;
  int         act_len  = 0;
  bit         skip_len = 1'b0;

  always @(negedge clk) begin
    rdy_seen = req_ready;
    if (mon_en) begin
      if (!reset_n && active) skip_len = 1'b1;
      if (!reset_n) cap_pend = 1'b0;
      if (cap_pend) begin
        cap_pend = 1'b0;
        check("capture_active", active, cur.cap);
        check("capture_value", value, cur.val);
        check("capture_owner", owner, cur.own);
      end
      if (req_ready != 3'b000) begin
        check("ready_single_cycle", prev_rdy, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got req_ready=%b expected none", req_ready);
        end else begin
          cur = exp_q.pop_front();
          check("grant_order", req_ready, cur.rdy);
          cap_pend = 1'b1;
        end
      end
      prev_rdy = req_ready;
      if (active) begin
        act_len++;
      end else if (act_len != 0) begin
        if (!skip_len) check("dwell_length", act_len, Dwell);
        act_len  = 0;
        skip_len = 1'b0;
      end
    end
  end

  // Requester model: drop valid after the accepting cycle unless told to hold it.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rdy_seen[i] && !hold[i]) req_valid[i] = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request(input int i, input logic [7:0] v);
    req_value[8*i +: 8] = v;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_grant(input int i, input logic [7:0] v);
    exp_t e;
    e.rdy = 3'(1 << i);
    e.cap = 1'b1;
    e.val = v;
    e.own = 2'(i);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || active || req_ready != 3'b000 || req_valid != 3'b000)
           && n < 200) begin
      tick();
      n++;
    end
    check("idle_reached", (n < 200), 1);
    tick(2);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("queue_drained", (n < 200), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t w;
    reset_n   = 1'b0;
    req_valid = 3'b000;
    req_value = 24'h0;
    tick(2);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    check("reset_value", value, 0);
    check("reset_owner", owner, 0);
    check("reset_active", active, 0);
    check("reset_ready", req_ready, 0);

    // Single request: latency and dwell window.
    request(0, 8'd43);
    expect_grant(0, 8'd43);
    tick();
    check("s1_ready_cycle1", req_ready, 3'b001);
    check("s1_value_before_capture", value, 0);
    tick();
    check("s1_value_cycle2", value, 43);
    check("s1_owner_cycle2", owner, 0);
    check("s1_active_cycle2", active, 1);
    tick(3);
    check("s1_active_cycle5", active, 1);
    tick();
    check("s1_active_cycle6", active, 0);
    check("s1_ready_cycle6", req_ready, 0);
    check("s1_value_held", value, 43);
    wait_idle();

    // Simultaneous requests: 0, 1, 2 in order, value changes 5 cycles apart.
    do_reset();
    request(0, 8'd10);
    request(1, 8'd99);
    request(2, 8'd127);
    expect_grant(0, 8'd10);
    expect_grant(1, 8'd99);
    expect_grant(2, 8'd127);
    tick(2);
    check("s2_value_c2", value, 10);
    tick(4);
    check("s2_value_c6", value, 10);
    check("s2_ready_c6", req_ready, 3'b010);
    tick();
    check("s2_value_c7", value, 99);
    tick(4);
    check("s2_ready_c11", req_ready, 3'b100);
    tick();
    check("s2_value_c12", value, 127);
    wait_idle();
    // Pointer wrapped back to 0: requester 0 wins over 1.
    request(1, 8'd20);
    request(0, 8'd21);
    expect_grant(0, 8'd21);
    expect_grant(1, 8'd20);
    wait_idle();

    // Fairness: requester 1 holds valid, requester 2 pulses mid-dwell.
    do_reset();
    hold[1] = 1'b1;
    request(1, 8'd55);
    expect_grant(1, 8'd55);
    tick(3);
    request(2, 8'd77);
    expect_grant(2, 8'd77);
    expect_grant(1, 8'd55);
    expect_grant(1, 8'd55);
    wait_drain();
    hold[1] = 1'b0;
    wait_idle();

    // Negative values pass through unmodified.
    request(0, 8'hFF);
    expect_grant(0, 8'hFF);
    wait_idle();
    request(0, 8'h81);
    expect_grant(0, 8'h81);
    wait_idle();
    check("s4_value_held_idle", value, 8'h81);

    // Withdrawn request: no capture, pointer unchanged (still 1).
    request(1, 8'd33);
    w.rdy = 3'b010;
    w.cap = 1'b0;
    w.val = 8'h81;
    w.own = 2'd0;
    exp_q.push_back(w);
    tick();
    req_valid[1] = 1'b0;
    check("s5_ready", req_ready, 3'b010);
    tick();
    check("s5_active_after", active, 0);
    check("s5_ready_after", req_ready, 0);
    tick();
    check("s5_still_idle", req_ready, 0);
    request(0, 8'd1);
    request(1, 8'd2);
    expect_grant(1, 8'd2);
    expect_grant(0, 8'd1);
    wait_idle();

    // Reset mid-dwell: outputs clear and pointer restarts at 0.
    request(0, 8'd99);
    expect_grant(0, 8'd99);
    tick(3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("s6_value", value, 0);
    check("s6_owner", owner, 0);
    check("s6_active", active, 0);
    check("s6_ready", req_ready, 0);
    request(0, 8'd5);
    request(1, 8'd6);
    expect_grant(0, 8'd5);
    expect_grant(1, 8'd6);
    wait_idle();

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
